fifo_queue_fwft: RTL and testbench

FIFO_QUEUE_FWFT -- requirements
Module: fifo_queue_fwft

---
 rtl/fifo_queue_fwft.sv | 146 ++++++++++++++
 tb/tb_fifo_queue_fwft.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_queue_fwft.sv
// Synchronous FIFO with an optional registered output stage.
// FWFT=1 presents the head entry directly; FWFT=0 adds one output register, which holds one extra word.
module fifo_queue_fwft #(
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 1
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  flush_in,
    input  logic [DATA_WIDTH-1:0] push_data_in,
    input  logic                  push_valid_in,
    output logic                  push_ready_out,
    output logic [DATA_WIDTH-1:0] pop_data_out,
    output logic                  pop_valid_out,
    input  logic                  pop_ready_in,
    output logic                  is_full_out,
    output logic                  is_empty_out,
    output logic                  almost_full_out,
    output logic                  almost_empty_out,
    output logic [PTR_WIDTH:0]    count_out,
    output logic [PTR_WIDTH:0]    peak_count_out
);

    localparam logic [PTR_WIDTH:0]   C_DEPTH   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   C_AF      = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0]   C_AE      = (PTR_WIDTH+1)'(AE_THRESH);
    localparam logic [PTR_WIDTH:0]   C_CNT_ONE = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] C_PTR_ONE = (PTR_WIDTH)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_rdPtr;
    logic [PTR_WIDTH-1:0]  r_wrPtr;
    logic [PTR_WIDTH:0]    r_count;
    logic [PTR_WIDTH:0]    r_peak;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_deq;
    logic                  w_popValid;
    logic                  w_countEmpty;
    logic [DATA_WIDTH-1:0] w_headData;
    logic [PTR_WIDTH:0]    w_countNext;
    logic [PTR_WIDTH:0]    w_peakNext;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign push_ready_out = ~flush_in & (r_count != C_DEPTH);
    assign w_push         = push_valid_in & push_ready_out;
    assign w_pop          = w_popValid & pop_ready_in;
    assign w_countEmpty   = (r_count == '0);

    generate
        if (FWFT != 0) begin : g_fwft
            assign w_popValid = ~flush_in & ~w_countEmpty;
            assign w_deq      = w_pop;
            assign w_headData = r_mem[r_rdPtr];
        end else begin : g_regOut
            logic                  r_outValid;
            logic [DATA_WIDTH-1:0] r_outData;

            // The stage refills from storage whenever it is empty or being drained.
            assign w_deq = ~flush_in & ~w_countEmpty & (~r_outValid | w_pop);

            always_ff @(posedge clk_in or posedge reset_in) begin
                if (reset_in) begin
                    r_outValid <= 1'b0;
                    r_outData  <= '0;
                end else if (flush_in) begin
                    r_outValid <= 1'b0;
                end else if (w_deq) begin
                    r_outValid <= 1'b1;
                    r_outData  <= r_mem[r_rdPtr];
                end else if (w_pop) begin
                    r_outValid <= 1'b0;
                end
            end

            assign w_popValid = r_outValid & ~flush_in;
            assign w_headData = r_outData;
        end
    endgenerate

    assign pop_valid_out = w_popValid;
    assign pop_data_out  = w_popValid ? w_headData : '0;

    always_comb begin
        w_countNext = r_count;
        if (flush_in) begin
            w_countNext = '0;
        end else if (w_push & ~w_deq) begin
            w_countNext = r_count + C_CNT_ONE;
        end else if (~w_push & w_deq) begin
            w_countNext = r_count - C_CNT_ONE;
        end
    end

    always_comb begin
        w_peakNext = r_peak;
        if (flush_in) begin
            w_peakNext = '0;
        end else if (w_countNext > r_peak) begin
            w_peakNext = w_countNext;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_peak  <= '0;
        end else begin
            r_count <= w_countNext;
            r_peak  <= w_peakNext;
            if (flush_in) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + C_PTR_ONE;
                end
                if (w_deq) begin
                    r_rdPtr <= r_rdPtr + C_PTR_ONE;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= push_data_in;
        end
    end

    assign count_out        = r_count;
    assign peak_count_out   = r_peak;
    assign is_full_out      = (r_count == C_DEPTH);
    assign is_empty_out     = w_countEmpty;
    assign almost_full_out  = (r_count >= C_AF);
    assign almost_empty_out = (r_count <= C_AE);

endmodule

// File: tb/tb_fifo_queue_fwft.sv
// Bench for fifo_queue_fwft: one FWFT=1 and one FWFT=0 instance share the same stimulus,
// each tracked by a queue-based model and checked every cycle, plus directed literal checks.
module tb_fifo_queue_fwft;

    logic        clk_in    = 1'b0;
    logic        reset_in  = 1'b1;
    logic        flush_in  = 1'b0;
    logic        pushValid = 1'b0;
    logic        popReady  = 1'b0;
    logic [31:0] pushData  = '0;

    logic        ready1, valid1, full1, empty1, af1, ae1;
    logic [31:0] data1;
    logic [2:0]  count1, peak1;
    logic        ready0, valid0, full0, empty0, af0, ae0;
    logic [31:0] data0;
    logic [2:0]  count0, peak0;

    int checks = 0;
    int errors = 0;

    logic [31:0] m1q[$];
    int          m1peak = 0;
    logic [31:0] m0q[$];
    bit          m0stage = 1'b0;
    int          m0peak = 0;

    logic [31:0] log1[$];
    logic [31:0] log0[$];

    always #5 clk_in = ~clk_in;

    fifo_queue_fwft #(.DEPTH(4), .PTR_WIDTH(2), .DATA_WIDTH(32), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u1 (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
        .push_data_in(pushData), .push_valid_in(pushValid), .push_ready_out(ready1),
        .pop_data_out(data1), .pop_valid_out(valid1), .pop_ready_in(popReady),
        .is_full_out(full1), .is_empty_out(empty1), .almost_full_out(af1), .almost_empty_out(ae1),
        .count_out(count1), .peak_count_out(peak1)
    );

    fifo_queue_fwft #(.DEPTH(4), .PTR_WIDTH(2), .DATA_WIDTH(32), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u0 (
        .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
        .push_data_in(pushData), .push_valid_in(pushValid), .push_ready_out(ready0),
        .pop_data_out(data0), .pop_valid_out(valid0), .pop_ready_in(popReady),
        .is_full_out(full0), .is_empty_out(empty0), .almost_full_out(af0), .almost_empty_out(ae0),
        .count_out(count0), .peak_count_out(peak0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic pv, input logic [31:0] pd, input logic pr);
        flush_in  = f;
        pushValid = pv;
        pushData  = pd;
        popReady  = pr;
        @(posedge clk_in);
        #2;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " u1 ready"}, ready1, 1);
        checkOutput({tag, " u1 empty"}, empty1, 1);
        checkOutput({tag, " u1 ae"}, ae1, 1);
        checkOutput({tag, " u1 valid"}, valid1, 0);
        checkOutput({tag, " u1 full"}, full1, 0);
        checkOutput({tag, " u1 af"}, af1, 0);
        checkOutput({tag, " u1 data"}, data1, 0);
        checkOutput({tag, " u1 count"}, count1, 0);
        checkOutput({tag, " u1 peak"}, peak1, 0);
        checkOutput({tag, " u0 ready"}, ready0, 1);
        checkOutput({tag, " u0 empty"}, empty0, 1);
        checkOutput({tag, " u0 valid"}, valid0, 0);
        checkOutput({tag, " u0 data"}, data0, 0);
        checkOutput({tag, " u0 count"}, count0, 0);
        checkOutput({tag, " u0 peak"}, peak0, 0);
    endtask

    // Model: FWFT=1 is a plain queue; FWFT=0 is a queue whose front may sit in the output stage.
    initial begin
        forever begin
            @(posedge clk_in or posedge reset_in);
            if (reset_in) begin
                m1q.delete(); m1peak = 0;
                m0q.delete(); m0stage = 1'b0; m0peak = 0;
            end else if (flush_in) begin
                m1q.delete(); m1peak = 0;
                m0q.delete(); m0stage = 1'b0; m0peak = 0;
            end else begin
                bit pop1, push1, pop0, push0, nextStage;
                int cnt0;
                pop1  = (m1q.size() != 0) && popReady;
                push1 = (m1q.size() != 4) && pushValid;
                if (pop1) void'(m1q.pop_front());
                if (push1) m1q.push_back(pushData);
                if (m1q.size() > m1peak) m1peak = m1q.size();

                cnt0  = m0q.size() - int'(m0stage);
                pop0  = m0stage && popReady;
                push0 = (cnt0 != 4) && pushValid;
                if (cnt0 != 0 && (!m0stage || pop0)) nextStage = 1'b1;
                else if (pop0) nextStage = 1'b0;
                else nextStage = m0stage;
                if (pop0) void'(m0q.pop_front());
                if (push0) m0q.push_back(pushData);
                m0stage = nextStage;
                if (m0q.size() - int'(m0stage) > m0peak) m0peak = m0q.size() - int'(m0stage);
            end
        end
    end

    // Every-cycle comparison against the model; also logs words that will pop on the next edge.
    initial begin
        forever begin
            int c1, c0;
            bit v1, v0;
            @(negedge clk_in);
            c1 = m1q.size();
            c0 = m0q.size() - int'(m0stage);
            v1 = !flush_in && c1 != 0;
            v0 = !flush_in && m0stage;
            checkOutput("u1 count", count1, c1);
            checkOutput("u1 peak", peak1, m1peak);
            checkOutput("u1 ready", ready1, !flush_in && c1 != 4);
            checkOutput("u1 valid", valid1, v1);
            checkOutput("u1 data", data1, v1 ? m1q[0] : 32'h0);
            checkOutput("u1 full", full1, c1 == 4);
            checkOutput("u1 empty", empty1, c1 == 0);
            checkOutput("u1 af", af1, c1 >= 3);
            checkOutput("u1 ae", ae1, c1 <= 1);
            checkOutput("u0 count", count0, c0);
            checkOutput("u0 peak", peak0, m0peak);
            checkOutput("u0 ready", ready0, !flush_in && c0 != 4);
            checkOutput("u0 valid", valid0, v0);
            checkOutput("u0 data", data0, v0 ? m0q[0] : 32'h0);
            checkOutput("u0 full", full0, c0 == 4);
            checkOutput("u0 empty", empty0, c0 == 0);
            checkOutput("u0 af", af0, c0 >= 3);
            checkOutput("u0 ae", ae0, c0 <= 1);
            if (valid1 && popReady) log1.push_back(data1);
            if (valid0 && popReady) log0.push_back(data0);
        end
    end

    initial begin
        #3;
        checkResetValues("por");
        @(posedge clk_in);
        @(posedge clk_in);
        #2 reset_in = 1'b0;

        // Fill the FWFT FIFO, then drain it in order.
        applyStimulus(0, 1, 32'hA1, 0);
        checkOutput("first push after reset u1 count", count1, 1);
        applyStimulus(0, 1, 32'hA2, 0);
        applyStimulus(0, 1, 32'hA3, 0);
        applyStimulus(0, 1, 32'hA4, 0);
        checkOutput("fill u1 count", count1, 4);
        checkOutput("fill u1 full", full1, 1);
        checkOutput("fill u1 ready", ready1, 0);
        checkOutput("fill u0 count", count0, 3);
        log1.delete(); log0.delete();
        repeat (4) applyStimulus(0, 0, 32'h0, 1);
        checkOutput("drain u1 empty", empty1, 1);
        checkOutput("drain u1 log size", log1.size(), 4);
        checkOutput("drain u0 log size", log0.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain u1 order", log1[i], 32'hA1 + i);
            checkOutput("drain u0 order", log0[i], 32'hA1 + i);
        end

        // Steady push+pop at one entry; the pointers wrap twice.
        applyStimulus(1, 0, 32'h0, 0);
        log1.delete(); log0.delete();
        applyStimulus(0, 1, 32'h100, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 1, 32'h100 + i, 1);
            checkOutput("wrap u1 count", count1, 1);
        end
        checkOutput("wrap u1 peak", peak1, 1);
        checkOutput("wrap u0 peak", peak0, 1);
        repeat (6) applyStimulus(0, 0, 32'h0, 1);
        checkOutput("wrap u1 log size", log1.size(), 11);
        checkOutput("wrap u0 log size", log0.size(), 11);
        for (int i = 0; i <= 10; i++) begin
            checkOutput("wrap u1 order", log1[i], 32'h100 + i);
            checkOutput("wrap u0 order", log0[i], 32'h100 + i);
        end

        // Registered stage: two-cycle latency and DEPTH+1 capacity.
        applyStimulus(1, 0, 32'h0, 0);
        log1.delete(); log0.delete();
        applyStimulus(0, 1, 32'hB1, 0);
        checkOutput("latency u0 valid after 1", valid0, 0);
        applyStimulus(0, 1, 32'hB2, 0);
        checkOutput("latency u0 valid after 2", valid0, 1);
        checkOutput("latency u0 data after 2", data0, 32'hB1);
        applyStimulus(0, 1, 32'hB3, 0);
        applyStimulus(0, 1, 32'hB4, 0);
        applyStimulus(0, 1, 32'hB5, 0);
        checkOutput("stage u0 count", count0, 4);
        checkOutput("stage u0 full", full0, 1);
        checkOutput("stage u0 ready", ready0, 0);
        checkOutput("stage u1 count", count1, 4);
        repeat (5) applyStimulus(0, 0, 32'h0, 1);
        checkOutput("stage u0 log size", log0.size(), 5);
        checkOutput("stage u1 log size", log1.size(), 4);
        for (int i = 0; i < 5; i++) checkOutput("stage u0 order", log0[i], 32'hB1 + i);
        checkOutput("stage u0 empty", empty0, 1);

        // Almost-full / almost-empty thresholds and peak tracking.
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h51, 0);
        applyStimulus(0, 1, 32'h52, 0);
        applyStimulus(0, 1, 32'h53, 0);
        checkOutput("flags u1 af", af1, 1);
        checkOutput("flags u1 ae", ae1, 0);
        applyStimulus(0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("flags u1 ae after pops", ae1, 1);
        checkOutput("flags u1 af after pops", af1, 0);
        checkOutput("flags u1 count", count1, 1);
        checkOutput("flags u1 peak", peak1, 3);

        // Flush wins over a same-cycle push.
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'hF1, 0);
        applyStimulus(0, 1, 32'hF2, 0);
        applyStimulus(0, 1, 32'hF3, 0);
        checkOutput("flush u1 count before", count1, 3);
        applyStimulus(1, 1, 32'hDEAD, 0);
        pushValid = 1'b0;
        flush_in  = 1'b0;
        #1;
        checkOutput("flush u1 count", count1, 0);
        checkOutput("flush u1 peak", peak1, 0);
        checkOutput("flush u1 valid", valid1, 0);
        checkOutput("flush u0 count", count0, 0);
        checkOutput("flush u0 peak", peak0, 0);
        checkOutput("flush u0 valid", valid0, 0);
        log1.delete(); log0.delete();
        repeat (4) applyStimulus(0, 0, 32'h0, 1);
        checkOutput("flush u1 nothing popped", log1.size(), 0);
        checkOutput("flush u0 nothing popped", log0.size(), 0);

        // Asynchronous reset between edges discards contents.
        applyStimulus(0, 1, 32'hE1, 0);
        applyStimulus(0, 1, 32'hE2, 0);
        checkOutput("mid reset u1 count before", count1, 2);
        pushValid = 1'b0;
        #1 reset_in = 1'b1;
        #1 checkResetValues("mid");
        @(posedge clk_in);
        #2 reset_in = 1'b0;
        log1.delete(); log0.delete();
        applyStimulus(0, 1, 32'hC1, 0);
        checkOutput("post reset u1 count", count1, 1);
        repeat (3) applyStimulus(0, 0, 32'h0, 1);
        checkOutput("post reset u1 log size", log1.size(), 1);
        checkOutput("post reset u1 first", log1[0], 32'hC1);
        checkOutput("post reset u0 log size", log0.size(), 1);
        checkOutput("post reset u0 first", log0[0], 32'hC1);

        applyStimulus(0, 0, 32'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
